exec_muldiv: RTL and testbench

- Iterative integer multiply/divide unit for the exec stage. It replaces the single-cycle MUL/DIV/MOD paths with a multicycle radix-2^BPC engine.
- Uses the exec-style handshake: enable in, done pulse out, plus rd tag passthrough and wselector for writeback.
- Sits beside the FPU path. The exec stage holds the pipeline while ready is low.

---
 rtl/exec_muldiv.sv | 187 ++++++++++++++++++
 tb/tb_exec_muldiv.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_muldiv.sv
// Iterative radix-2^BPC multiply/divide unit for the exec stage.
// Shift-add multiply and restoring divide on magnitudes, with the sign fixed up in FIN.
module exec_muldiv #(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            enable,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs,
  input  logic [XLEN-1:0] rt,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] data,
  output logic [4:0]      rd_out,
  output logic [2:0]      wselector
);

  localparam int N  = XLEN / BPC;
  localparam int CW = $clog2(N + 1);
  localparam int MW = XLEN + BPC;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHU  = 3'b010;
  localparam logic [2:0] OP_MULHSU = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      op_q;
  logic [4:0]      rd_q;
  logic            neg_q;
  logic            neg_r;
  // hi: product high half / partial remainder; lo: multiplier+product low / quotient
  logic [XLEN:0]   hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] opb;

  logic            is_div;
  logic            a_signed;
  logic            b_signed;
  logic            a_neg;
  logic            b_neg;
  logic            special;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;

  always_comb begin
    is_div   = op[2];
    a_signed = (op != OP_MULHU) && (op != OP_DIVU) && (op != OP_REMU);
    b_signed = a_signed && (op != OP_MULHSU);
    a_neg    = a_signed && rs[XLEN-1];
    b_neg    = b_signed && rt[XLEN-1];
    a_mag    = a_neg ? -rs : rs;
    b_mag    = b_neg ? -rt : rt;
    // Divide by zero and signed overflow have fixed answers and bypass RUN.
    special  = is_div && ((rt == '0) ||
               (!op[0] && (rs == {1'b1, {(XLEN-1){1'b0}}}) && (rt == '1)));
  end

  logic [MW-1:0]     pp;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_r;
  logic [XLEN-1:0]   div_q;

  always_comb begin
    pp       = MW'(hi[XLEN-1:0]) + MW'(opb) * MW'(lo[BPC-1:0]);
    mul_next = {pp, lo[XLEN-1:BPC]};
    div_r    = hi;
    div_q    = lo;
    // NOTE: blocking assignments here chain BPC restoring steps within one cycle.
    for (int i = 0; i < BPC; i++) begin
      div_r = {div_r[XLEN-1:0], div_q[XLEN-1]};
      div_q = {div_q[XLEN-2:0], 1'b0};
      if (div_r >= {1'b0, opb}) begin
        div_r    = div_r - {1'b0, opb};
        div_q[0] = 1'b1;
      end
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   result;

  always_comb begin
    // NOTE: every output of this block gets a value on all paths, so no latch is inferred.
    prod   = {hi[XLEN-1:0], lo};
    if (neg_q) prod = -prod;
    quot   = neg_q ? -lo : lo;
    rem    = neg_r ? -hi[XLEN-1:0] : hi[XLEN-1:0];
    result = '0;
    case (op_q)
      OP_MUL:                      result = prod[XLEN-1:0];
      OP_MULH, OP_MULHU,
      OP_MULHSU:                   result = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             result = quot;
      OP_REM, OP_REMU:             result = rem;
      default:                     result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      opb       <= '0;
      done      <= 1'b0;
      wselector <= 3'b000;
      data      <= '0;
      rd_out    <= '0;
    end else begin
      // NOTE: non-blocking for all state; done and wselector default low to form a pulse.
      done      <= 1'b0;
      wselector <= 3'b000;
      case (state)
        IDLE: begin
          if (enable && !flush) begin
            op_q <= op;
            rd_q <= rd_in;
            if (special) begin
              state <= FIN;
              cnt   <= '0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              opb   <= '0;
              lo    <= (rt == '0) ? '1 : rs;
              hi    <= (rt == '0) ? {1'b0, rs} : '0;
            end else begin
              state <= RUN;
              cnt   <= CW'(N);
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              hi    <= '0;
              lo    <= is_div ? a_mag : b_mag;
              opb   <= is_div ? b_mag : a_mag;
            end
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= FIN;
            if (op_q[2]) begin
              hi <= div_r;
              lo <= div_q;
            end else begin
              hi <= {1'b0, mul_next[2*XLEN-1:XLEN]};
              lo <= mul_next[XLEN-1:0];
            end
          end
        end
        FIN: begin
          state <= IDLE;
          if (!flush) begin
            done      <= 1'b1;
            wselector <= 3'b010;
            data      <= result;
            rd_out    <= rd_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready = (state == IDLE);

endmodule

// File: tb/tb_exec_muldiv.sv
// Bench for exec_muldiv: three instances (BPC=1,2,4) checked against an arithmetic model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_exec_muldiv;

  localparam int XLEN = 32;
  localparam int NDUT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NDUT-1:0] rstn;
  logic [NDUT-1:0] enable;
  logic [NDUT-1:0] flush;
  logic [NDUT-1:0] ready;
  logic [NDUT-1:0] done;
  logic [2:0]      op;
  logic [31:0]     rs;
  logic [31:0]     rt;
  logic [4:0]      rd_in;
  logic [31:0]     data   [NDUT];
  logic [4:0]      rd_out [NDUT];
  logic [2:0]      wsel   [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    exec_muldiv #(.XLEN(XLEN), .BPC(1 << g)) dut (
      .clk(clk), .rstn(rstn[g]), .enable(enable[g]), .op(op), .rs(rs), .rt(rt),
      .rd_in(rd_in), .flush(flush[g]), .ready(ready[g]), .done(done[g]),
      .data(data[g]), .rd_out(rd_out[g]), .wselector(wsel[g])
    );
  end

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_tag = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return o[2] && ((b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic int exp_lat(input int g, input logic spec);
    return spec ? 2 : (XLEN >> g) + 2;
  endfunction

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    int          ia, ib;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ia  = $signed(a);
    ib  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 64'(sa * sb);
    case (o)
      3'd0: return p[31:0];
      3'd1: return p[63:32];
      3'd2: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd3: begin p = 64'(sa * longint'({32'b0, b})); return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one op to all instances; check latency, result, tag, wselector and done count.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    logic [31:0] exp_res;
    logic        spec;
    int          nd [NDUT];
    int          span;
    exp_res = model(o, a, b);
    spec    = is_special(o, a, b);
    span    = spec ? 4 : exp_lat(0, 1'b0) + 2;
    for (int g = 0; g < NDUT; g++) nd[g] = 0;
    op = o; rs = a; rt = b; rd_in = tag; enable = '1;
    for (int c = 1; c <= span; c++) begin
      @(negedge clk);
      enable = '0;
      op = 3'($urandom); rs = $urandom; rt = $urandom; rd_in = 5'($urandom);
      for (int g = 0; g < NDUT; g++) begin
        if (done[g]) begin
          nd[g]++;
          check($sformatf("latency d%0d op%0d", g, o), 32'(c), 32'(exp_lat(g, spec)));
          check($sformatf("data d%0d op%0d %h,%h", g, o, a, b), data[g], exp_res);
          check($sformatf("rd_out d%0d", g), 32'(rd_out[g]), 32'(tag));
          check($sformatf("wselector d%0d", g), 32'(wsel[g]), 32'h2);
          check($sformatf("ready_in_done d%0d", g), 32'(ready[g]), 32'h1);
        end
      end
    end
    for (int g = 0; g < NDUT; g++) check($sformatf("done_count d%0d op%0d", g, o), 32'(nd[g]), 32'h1);
    last_res = exp_res;
    last_tag = tag;
  endtask

  task automatic flush_test();
    int fc [NDUT];
    int nd [NDUT];
    fc[0] = 10; fc[1] = 10; fc[2] = 9;  // d2 is in FIN at cycle 9
    for (int g = 0; g < NDUT; g++) nd[g] = 0;
    op = 3'b100; rs = 32'h0001_2345; rt = 32'h0000_0007; rd_in = 5'd17; enable = '1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      enable = '0;
      for (int g = 0; g < NDUT; g++) begin
        if (done[g]) nd[g]++;
        if (c == fc[g] + 1) check($sformatf("flush_ready d%0d", g), 32'(ready[g]), 32'h1);
        flush[g] = (c == fc[g]);
      end
    end
    for (int g = 0; g < NDUT; g++) begin
      check($sformatf("flush_no_done d%0d", g), 32'(nd[g]), 32'h0);
      check($sformatf("flush_data_kept d%0d", g), data[g], last_res);
      check($sformatf("flush_tag_kept d%0d", g), 32'(rd_out[g]), 32'(last_tag));
    end
  endtask

  task automatic flush_enable_idle();
    int nd [NDUT];
    for (int g = 0; g < NDUT; g++) nd[g] = 0;
    op = 3'b000; rs = 32'd3; rt = 32'd4; rd_in = 5'd3; enable = '1; flush = '1;
    @(negedge clk);
    enable = '0; flush = '0;
    for (int g = 0; g < NDUT; g++) check($sformatf("fe_ready d%0d", g), 32'(ready[g]), 32'h1);
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) if (done[g]) nd[g]++;
    end
    for (int g = 0; g < NDUT; g++) begin
      check($sformatf("fe_no_done d%0d", g), 32'(nd[g]), 32'h0);
      check($sformatf("fe_data_kept d%0d", g), data[g], last_res);
    end
  endtask

  task automatic back_to_back();
    int          nd [NDUT];
    int          t1 [NDUT];
    logic [31:0] r1, r2;
    r1 = model(3'b000, 32'd7, 32'hFFFF_FFFD);
    r2 = model(3'b101, 32'hFFFF_FFF9, 32'd2);
    for (int g = 0; g < NDUT; g++) begin nd[g] = 0; t1[g] = 0; end
    op = 3'b000; rs = 32'd7; rt = 32'hFFFF_FFFD; rd_in = 5'd5; enable = '1;
    for (int c = 1; c <= 76; c++) begin
      @(negedge clk);
      enable = '0;
      if (c == 1) begin op = 3'b101; rs = 32'hFFFF_FFF9; rt = 32'd2; rd_in = 5'd9; end
      for (int g = 0; g < NDUT; g++) begin
        if (done[g]) begin
          nd[g]++;
          if (nd[g] == 1) begin
            check($sformatf("b2b_first d%0d", g), data[g], r1);
            check($sformatf("b2b_ready d%0d", g), 32'(ready[g]), 32'h1);
            t1[g] = c;
            enable[g] = 1'b1;
          end else begin
            check($sformatf("b2b_second d%0d", g), data[g], r2);
            check($sformatf("b2b_gap d%0d", g), 32'(c - t1[g]), 32'(exp_lat(g, 1'b0)));
            check($sformatf("b2b_tag d%0d", g), 32'(rd_out[g]), 32'd9);
          end
        end
      end
    end
    for (int g = 0; g < NDUT; g++) check($sformatf("b2b_count d%0d", g), 32'(nd[g]), 32'h2);
    last_res = r2;
    last_tag = 5'd9;
  endtask

  task automatic busy_enable();
    int          nd [NDUT];
    logic [31:0] r1;
    r1 = model(3'b010, 32'hDEAD_BEEF, 32'h1234_5678);
    for (int g = 0; g < NDUT; g++) nd[g] = 0;
    op = 3'b010; rs = 32'hDEAD_BEEF; rt = 32'h1234_5678; rd_in = 5'd11; enable = '1;
    for (int c = 1; c <= 44; c++) begin
      @(negedge clk);
      if (c == 1) begin op = 3'b000; rs = 32'd9; rt = 32'd9; rd_in = 5'd1; end
      enable = (c >= 3 && c <= 5) ? '1 : '0;
      for (int g = 0; g < NDUT; g++) begin
        if (done[g]) begin
          nd[g]++;
          check($sformatf("busy_data d%0d", g), data[g], r1);
        end
      end
    end
    for (int g = 0; g < NDUT; g++) check($sformatf("busy_count d%0d", g), 32'(nd[g]), 32'h1);
    last_res = r1;
    last_tag = 5'd11;
  endtask

  task automatic reset_mid_op();
    int rc [NDUT];
    int nd [NDUT];
    rc[0] = 20; rc[1] = 10; rc[2] = 5;
    for (int g = 0; g < NDUT; g++) nd[g] = 0;
    op = 3'b000; rs = 32'h0000_1234; rt = 32'h0000_5678; rd_in = 5'd21; enable = '1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      enable = '0;
      for (int g = 0; g < NDUT; g++) begin
        if (done[g]) nd[g]++;
        if (c == rc[g] + 1) begin
          check($sformatf("rst_ready d%0d", g), 32'(ready[g]), 32'h1);
          check($sformatf("rst_done d%0d", g), 32'(done[g]), 32'h0);
          check($sformatf("rst_data d%0d", g), data[g], 32'h0);
          check($sformatf("rst_rd d%0d", g), 32'(rd_out[g]), 32'h0);
          check($sformatf("rst_wsel d%0d", g), 32'(wsel[g]), 32'h0);
          rstn[g] = 1'b1;
        end
        if (c == rc[g]) rstn[g] = 1'b0;
      end
    end
    for (int g = 0; g < NDUT; g++) check($sformatf("rst_no_done d%0d", g), 32'(nd[g]), 32'h0);
    last_res = '0;
    last_tag = '0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      6: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rstn = '0; enable = '0; flush = '0; op = '0; rs = '0; rt = '0; rd_in = '0;
    repeat (2) @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      check($sformatf("reset_ready d%0d", g), 32'(ready[g]), 32'h1);
      check($sformatf("reset_done d%0d", g), 32'(done[g]), 32'h0);
      check($sformatf("reset_data d%0d", g), data[g], 32'h0);
      check($sformatf("reset_rd d%0d", g), 32'(rd_out[g]), 32'h0);
      check($sformatf("reset_wsel d%0d", g), 32'(wsel[g]), 32'h0);
    end
    rstn = '1;
    @(negedge clk);

    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
    run_op(3'b011, 32'hFFFF_FFFF, 32'd2, 5'd8);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd9);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd10);
    run_op(3'b101, 32'hFFFF_FFF9, 32'd2, 5'd11);
    run_op(3'b111, 32'hFFFF_FFF9, 32'd2, 5'd12);
    run_op(3'b100, 32'd123, 32'd0, 5'd13);
    run_op(3'b111, 32'd123, 32'd0, 5'd14);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);

    flush_test();
    flush_enable_idle();
    back_to_back();
    busy_enable();

    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom));
    end

    reset_mid_op();
    run_op(3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 5'd30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
